// File: rtl/fe25519_pkg.sv
// -----------------------------------------------------------------------------
// fe25519_pkg
// Shared constants and types for the GF(2^255-19) arithmetic pipeline.
//   P_25519    field prime 2^255-19
//   FOLD256    2^256 mod p (38), used by the first reduction fold
//   FOLD255    2^255 mod p (19), used by the second reduction fold
//   fe_op_e    operation encoding on in_op
//   FE_ALU_LAT acceptance-to-result latency of the pipeline in cycles
// -----------------------------------------------------------------------------
package fe25519_pkg;

   localparam logic [254:0] P_25519 = {255{1'b1}} - 255'd18;
   localparam logic [5:0]   FOLD256 = 6'd38;
   localparam logic [4:0]   FOLD255 = 5'd19;
   localparam int           FE_ALU_LAT = 4;

   typedef enum logic [1:0] {
      FE_MUL = 2'b00,
      FE_SQR = 2'b01,
      FE_ADD = 2'b10,
      FE_SUB = 2'b11
   } fe_op_e;

endpackage

// File: rtl/fe25519_kara_mul.sv
// -----------------------------------------------------------------------------
// fe25519_kara_mul
// 256x256 -> 512 bit Karatsuba multiplier. Leaf products are registered (S1);
// recombination is combinational and is captured by the parent's S2 register.
//   clk   in   clock
//   en_i  in   pipeline advance; leaf registers hold while low
//   a_i   in   256b operand (from S0)
//   b_i   in   256b operand (from S0)
//   z_o   out  512b product a*b, valid one cycle after a_i/b_i were captured
// KARA_LEVELS = 1 : three 129x129 leaf multiplies
// KARA_LEVELS = 2 : nine 66x66 leaf multiplies
// -----------------------------------------------------------------------------
module fe25519_kara_mul #(
   parameter int KARA_LEVELS = 2
) (
   input  logic         clk,
   input  logic         en_i,
   input  logic [255:0] a_i,
   input  logic [255:0] b_i,
   output logic [511:0] z_o
);

   // First-level split: index 0 = low halves, 1 = high halves, 2 = half sums.
   logic [128:0] u [3];
   logic [128:0] v [3];
   logic [257:0] pl [3];

   always_comb begin
      u[0] = {1'b0, a_i[127:0]};
      u[1] = {1'b0, a_i[255:128]};
      u[2] = {1'b0, a_i[127:0]} + {1'b0, a_i[255:128]};
      v[0] = {1'b0, b_i[127:0]};
      v[1] = {1'b0, b_i[255:128]};
      v[2] = {1'b0, b_i[127:0]} + {1'b0, b_i[255:128]};
   end

   generate
      if (KARA_LEVELS == 1) begin : g_l1
         logic [257:0] leaf_q [3];

         // NOTE: datapath registers carry no reset; only the valid bits need a
         // known state, and the wide leaf products stay cheap without one.
         // NOTE: sequential state is always written with <= so that every
         // register samples pre-edge values regardless of statement order.
         always_ff @(posedge clk) begin
            if (en_i) begin
               for (int i = 0; i < 3; i++) begin
                  leaf_q[i] <= {129'b0, u[i]} * {129'b0, v[i]};
               end
            end
         end

         always_comb begin
            for (int i = 0; i < 3; i++) begin
               pl[i] = leaf_q[i];
            end
         end
      end else if (KARA_LEVELS == 2) begin : g_l2
         // Second-level split of each first-level pair at bit 64:
         // slot 3i = low, 3i+1 = high, 3i+2 = sum.
         logic [65:0]  x [9];
         logic [65:0]  y [9];
         logic [131:0] leaf_q [9];

         always_comb begin
            for (int i = 0; i < 3; i++) begin
               x[3*i]   = {2'b0, u[i][63:0]};
               x[3*i+1] = {1'b0, u[i][128:64]};
               x[3*i+2] = {2'b0, u[i][63:0]} + {1'b0, u[i][128:64]};
               y[3*i]   = {2'b0, v[i][63:0]};
               y[3*i+1] = {1'b0, v[i][128:64]};
               y[3*i+2] = {2'b0, v[i][63:0]} + {1'b0, v[i][128:64]};
            end
         end

         always_ff @(posedge clk) begin
            if (en_i) begin
               for (int j = 0; j < 9; j++) begin
                  leaf_q[j] <= {66'b0, x[j]} * {66'b0, y[j]};
               end
            end
         end

         // The true first-level product fits in 258 bits, so wrap-around
         // arithmetic at that width recombines it exactly.
         always_comb begin
            for (int i = 0; i < 3; i++) begin
               pl[i] = ({126'b0, leaf_q[3*i+1]} << 128)
                     + (({126'b0, leaf_q[3*i+2]} - {126'b0, leaf_q[3*i]}
                         - {126'b0, leaf_q[3*i+1]}) << 64)
                     + {126'b0, leaf_q[3*i]};
            end
         end
      end else begin : g_bad
         $error("fe25519_kara_mul: KARA_LEVELS must be 1 or 2");
         always_comb begin
            for (int i = 0; i < 3; i++) begin
               pl[i] = '0;
            end
         end
      end
   endgenerate

   // Product < 2^512, so modular 512-bit recombination is exact.
   assign z_o = ({254'b0, pl[1]} << 256)
              + (({254'b0, pl[2]} - {254'b0, pl[0]} - {254'b0, pl[1]}) << 128)
              + {254'b0, pl[0]};

endmodule

// File: rtl/fe25519_alu_pipe.sv
// -----------------------------------------------------------------------------
// fe25519_alu_pipe
// Four-stage pipelined GF(2^255-19) unit: MUL, SQR, ADD, SUB with valid/ready
// flow control, tag pass-through and canonical result in [0,p).
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready = pipeline advance)
//   in_op               00 MUL, 01 SQR (in_b ignored), 10 ADD, 11 SUB
//   in_a, in_b          256b operands, need not be reduced
//   in_tag              returned unchanged with the result
//   out_valid/out_ready result handshake
//   out_res             255b canonical result
//   out_tag             tag belonging to out_res
//   busy                any stage holds a valid op
// Stages: S0 operand capture / add-sub, S1 leaf products, S2 recombine and
// fold by 38, S3 fold by 19 and final conditional subtract into out_res.
// -----------------------------------------------------------------------------
module fe25519_alu_pipe
   import fe25519_pkg::*;
#(
   parameter int TAG_W       = 8,
   parameter int KARA_LEVELS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [255:0]     in_a,
   input  logic [255:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [254:0]     out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   // 4p as 258 bits: adding it before subtracting b keeps SUB non-negative.
   localparam logic [257:0] P_X4 = {1'b0, P_25519, 2'b00};

   logic adv;
   logic v0_q, v1_q, v2_q, out_valid_q;

   // The whole pipe advances together whenever the output slot is free or taken.
   assign adv       = ~out_valid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign busy      = v0_q | v1_q | v2_q | out_valid_q;

   // ---------------- S0 ----------------
   fe_op_e       op_d;
   logic [255:0] b_d;
   logic [257:0] s_d;
   logic [255:0] a0_q, b0_q;
   logic [257:0] s0_q;
   logic         mul0_q;
   logic [TAG_W-1:0] tag0_q;

   assign op_d = fe_op_e'(in_op);
   assign b_d  = (op_d == FE_SQR) ? in_a : in_b;
   assign s_d  = (op_d == FE_SUB) ? ({2'b0, in_a} + P_X4 - {2'b0, in_b})
                                  : ({2'b0, in_a} + {2'b0, in_b});

   // ---------------- S1 ----------------
   logic [257:0] s1_q;
   logic         mul1_q;
   logic [TAG_W-1:0] tag1_q;
   logic [511:0] z;

   fe25519_kara_mul #(
      .KARA_LEVELS (KARA_LEVELS)
   ) u_kara (
      .clk  (clk),
      .en_i (adv),
      .a_i  (a0_q),
      .b_i  (b0_q),
      .z_o  (z)
   );

   // ---------------- S2 ----------------
   // ADD/SUB results share the fold path; their high half is at most 3.
   logic [511:0] z_sel;
   logic [262:0] f2_d, f2_q;
   logic [TAG_W-1:0] tag2_q;

   assign z_sel = mul1_q ? z : {254'b0, s1_q};
   assign f2_d  = {7'b0, z_sel[255:0]}
                + ({7'b0, z_sel[511:256]} * {257'b0, FOLD256});

   // ---------------- S3 ----------------
   // x < 2^255 + 4845 < 2p, so a single conditional subtract suffices.
   // Subtracting p modulo 2^255 is the same as adding 19, which also covers
   // the case x[255]=1 without carrying a 256-bit difference.
   logic [255:0] x3;
   logic         ge_p;
   logic [254:0] res_d;

   assign x3    = {1'b0, f2_q[254:0]} + ({248'b0, f2_q[262:255]} * {251'b0, FOLD255});
   assign ge_p  = x3[255] | (x3[254:0] >= P_25519);
   assign res_d = ge_p ? (x3[254:0] + 255'd19) : x3[254:0];

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_res     <= '0;
         out_tag     <= '0;
      end else if (adv) begin
         v0_q        <= in_valid;
         v1_q        <= v0_q;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         if (v2_q) begin
            out_res <= res_d;
            out_tag <= tag2_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         a0_q   <= in_a;
         b0_q   <= b_d;
         s0_q   <= s_d;
         mul0_q <= ~in_op[1];
         tag0_q <= in_tag;
         s1_q   <= s0_q;
         mul1_q <= mul0_q;
         tag1_q <= tag0_q;
         f2_q   <= f2_d;
         tag2_q <= tag1_q;
      end
   end

endmodule

// File: tb/tb_fe25519_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_fe25519_alu_pipe
// Directed and randomised checks of fe25519_alu_pipe: reset state, latency,
// hand-computed field results, back-pressure ordering, reset mid-flight.
// -----------------------------------------------------------------------------
module tb_fe25519_alu_pipe;

   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_SQR = 2'd1;
   localparam logic [1:0] OP_ADD = 2'd2;
   localparam logic [1:0] OP_SUB = 2'd3;

   localparam logic [255:0] P    = (256'd1 << 255) - 256'd19;
   localparam logic [255:0] ONES = {256{1'b1}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_op;
   logic [255:0] in_a;
   logic [255:0] in_b;
   logic [7:0]   in_tag;
   logic         out_valid;
   logic         out_ready;
   logic [254:0] out_res;
   logic [7:0]   out_tag;
   logic         busy;

   fe25519_alu_pipe #(
      .TAG_W       (8),
      .KARA_LEVELS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [255:0] a;
      logic [255:0] b;
      logic [7:0]   tag;
      logic [255:0] exp;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   vec_t         req_q[$];
   logic [254:0] obs_res[$];
   logic [7:0]   obs_tag[$];
   int           hold_err;
   bit           saw_stall;
   bit           timed_out;

   function automatic vec_t mk(input logic [1:0] op, input logic [255:0] a,
                               input logic [255:0] b, input logic [255:0] exp);
      vec_t v;
      v.op  = op;
      v.a   = a;
      v.b   = b;
      v.tag = 8'd0;
      v.exp = exp;
      return v;
   endfunction

   // Straightforward bignum reference: reduce operands, operate, reduce.
   function automatic logic [255:0] model(input logic [1:0] op, input logic [255:0] a,
                                          input logic [255:0] b);
      logic [511:0] pp, aa, bb, r;
      pp = {256'b0, P};
      aa = {256'b0, a} % pp;
      bb = {256'b0, b} % pp;
      case (op)
         OP_MUL:  r = (aa * bb) % pp;
         OP_SQR:  r = (aa * aa) % pp;
         OP_ADD:  r = (aa + bb) % pp;
         default: r = (aa + pp - bb) % pp;
      endcase
      return r[255:0];
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      case ($urandom_range(15))
         0: r = '0;
         1: r = P;
         2: r = P << 1;
         3: r = ONES;
         4: r = P - 256'd1;
         default: ;
      endcase
      return r;
   endfunction

   // Streams req_q through the DUT and records every consumed result.
   task automatic pump(input int stall, input int rdy_pct, input int vld_pct, input int budget);
      int           cyc = 0;
      bit           prev_hold = 1'b0;
      logic [254:0] prev_res = '0;
      logic [7:0]   prev_tag = '0;
      obs_res.delete();
      obs_tag.delete();
      hold_err  = 0;
      saw_stall = 1'b0;
      while ((req_q.size() != 0 || busy) && cyc < budget) begin
         out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         in_valid  = (req_q.size() != 0) && ($urandom_range(99) < vld_pct);
         if (req_q.size() != 0) begin
            in_op  = req_q[0].op;
            in_a   = req_q[0].a;
            in_b   = req_q[0].b;
            in_tag = req_q[0].tag;
         end
         #1;
         if (prev_hold && (!out_valid || out_res !== prev_res || out_tag !== prev_tag))
            hold_err++;
         prev_hold = out_valid && !out_ready;
         prev_res  = out_res;
         prev_tag  = out_tag;
         if (out_valid && !in_ready) saw_stall = 1'b1;
         if (out_valid && out_ready) begin
            obs_res.push_back(out_res);
            obs_tag.push_back(out_tag);
         end
         if (in_valid && in_ready) void'(req_q.pop_front());
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      timed_out = (req_q.size() != 0) || busy;
   endtask

   // Issues one op with out_ready high and counts cycles until out_valid.
   task automatic issue_one(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b,
                            input logic [7:0] tag, output int lat, output logic [254:0] res,
                            output logic [7:0] t);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_b     = ONES;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = out_res;
      t   = out_tag;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_op     = OP_MUL;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++;
      if (out_res !== 255'd0) begin n_bad++; $display("FAIL reset_out_res got %h want 0", out_res); end
      n_vec++;
      if (out_tag !== 8'd0) begin n_bad++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      int lat;
      logic [254:0] res;
      logic [7:0] t;
      issue_one(OP_MUL, P - 256'd1, P - 256'd1, 8'hA5, lat, res, t);
      n_vec++;
      if (lat != 4) begin n_bad++; $display("FAIL latency got %0d want 4", lat); end
      n_vec++;
      if (res !== 255'd1) begin n_bad++; $display("FAIL lat_res got %h want 1", res); end
      n_vec++;
      if (t !== 8'hA5) begin n_bad++; $display("FAIL lat_tag got %h want a5", t); end
   endtask

   task automatic test_directed();
      vec_t v[$];
      v.push_back(mk(OP_MUL, P - 256'd1, P - 256'd1, 256'd1));
      v.push_back(mk(OP_MUL, P, 256'd5, 256'd0));
      v.push_back(mk(OP_MUL, ONES, ONES, 256'd1369));
      v.push_back(mk(OP_SQR, 256'd2, ONES, 256'd4));
      v.push_back(mk(OP_ADD, P - 256'd1, 256'd1, 256'd0));
      v.push_back(mk(OP_SUB, 256'd0, 256'd1, P - 256'd1));
      v.push_back(mk(OP_SUB, 256'd5, P + 256'd5, 256'd0));
      v.push_back(mk(OP_ADD, ONES, ONES, 256'd74));
      v.push_back(mk(OP_SUB, ONES, 256'd0, 256'd37));
      v.push_back(mk(OP_MUL, 256'd1 << 255, 256'd2, 256'd38));
      v.push_back(mk(OP_ADD, P - 256'd1, P - 256'd1, P - 256'd2));
      v.push_back(mk(OP_ADD, P << 1, 256'd0, 256'd0));
      v.push_back(mk(OP_MUL, 256'd1 << 128, 256'd1 << 128, 256'd38));
      v.push_back(mk(OP_SUB, 256'd0, ONES, P - 256'd37));
      v.push_back(mk(OP_MUL, 256'd3, P + 256'd2, 256'd6));
      v.push_back(mk(OP_MUL, ONES, 256'd1, 256'd37));
      for (int i = 0; i < v.size(); i++) begin
         v[i].tag = 8'(i + 16);
         req_q.push_back(v[i]);
      end
      pump(0, 100, 100, 200);
      n_vec++;
      if (timed_out) begin n_bad++; $display("FAIL dir_timeout got drained=0 want 1"); end
      n_vec++;
      if (obs_res.size() != v.size()) begin
         n_bad++;
         $display("FAIL dir_count got %0d want %0d", obs_res.size(), v.size());
      end else begin
         for (int i = 0; i < v.size(); i++) begin
            n_vec++;
            if ({1'b0, obs_res[i]} !== v[i].exp) begin
               n_bad++;
               $display("FAIL dir_res[%0d] got %h want %h", i, obs_res[i], v[i].exp);
            end
            n_vec++;
            if (obs_tag[i] !== v[i].tag) begin
               n_bad++;
               $display("FAIL dir_tag[%0d] got %h want %h", i, obs_tag[i], v[i].tag);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         vec_t e;
         e     = mk(OP_SQR, 256'(i + 3), ONES, 256'((i + 3) * (i + 3)));
         e.tag = 8'(i);
         req_q.push_back(e);
      end
      pump(6, 100, 100, 100);
      n_vec++;
      if (timed_out) begin n_bad++; $display("FAIL b2b_timeout got drained=0 want 1"); end
      n_vec++;
      if (!saw_stall) begin n_bad++; $display("FAIL b2b_in_ready_drop got 0 want 1"); end
      n_vec++;
      if (hold_err != 0) begin n_bad++; $display("FAIL b2b_hold got %0d want 0", hold_err); end
      n_vec++;
      if (obs_res.size() != 6) begin
         n_bad++;
         $display("FAIL b2b_count got %0d want 6", obs_res.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (obs_tag[i] !== 8'(i)) begin
               n_bad++;
               $display("FAIL b2b_tag[%0d] got %h want %h", i, obs_tag[i], 8'(i));
            end
            n_vec++;
            if (obs_res[i] !== 255'((i + 3) * (i + 3))) begin
               n_bad++;
               $display("FAIL b2b_res[%0d] got %h want %0d", i, obs_res[i], (i + 3) * (i + 3));
            end
         end
      end
   endtask

   task automatic test_random();
      vec_t v[$];
      for (int i = 0; i < 300; i++) begin
         vec_t e;
         e.op  = 2'($urandom_range(3));
         e.a   = rnd256();
         e.b   = rnd256();
         e.tag = 8'(i);
         e.exp = model(e.op, e.a, e.b);
         v.push_back(e);
         req_q.push_back(e);
      end
      pump(0, 70, 70, 4000);
      n_vec++;
      if (timed_out) begin n_bad++; $display("FAIL rnd_timeout got drained=0 want 1"); end
      n_vec++;
      if (hold_err != 0) begin n_bad++; $display("FAIL rnd_hold got %0d want 0", hold_err); end
      n_vec++;
      if (obs_res.size() != v.size()) begin
         n_bad++;
         $display("FAIL rnd_count got %0d want %0d", obs_res.size(), v.size());
      end else begin
         for (int i = 0; i < v.size(); i++) begin
            n_vec++;
            if ({1'b0, obs_res[i]} !== v[i].exp || obs_tag[i] !== v[i].tag) begin
               n_bad++;
               $display("FAIL rnd[%0d] op=%0d got %h/%h want %h/%h", i, v[i].op,
                        obs_res[i], obs_tag[i], v[i].exp, v[i].tag);
            end
            n_vec++;
            if ({1'b0, obs_res[i]} >= P) begin
               n_bad++;
               $display("FAIL rnd_canon[%0d] got %h want below p", i, obs_res[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      int lat;
      logic [254:0] res;
      logic [7:0] t;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_op    = OP_MUL;
         in_a     = P - 256'd1;
         in_b     = P - 256'd1;
         in_tag   = 8'(i + 64);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_inflight got busy=%b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
      n_vec++;
      if (out_res !== 255'd0) begin n_bad++; $display("FAIL rmid_out_res got %h want 0", out_res); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) stale++;
      end
      n_vec++;
      if (stale != 0) begin n_bad++; $display("FAIL rmid_stale got %0d want 0", stale); end
      issue_one(OP_MUL, 256'd3, 256'd7, 8'h09, lat, res, t);
      n_vec++;
      if (lat != 4) begin n_bad++; $display("FAIL rmid_latency got %0d want 4", lat); end
      n_vec++;
      if (res !== 255'd21 || t !== 8'h09) begin
         n_bad++;
         $display("FAIL rmid_first got %h/%h want 15/09", res, t);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
